// File: rtl/noc_out_port_buffer.sv
// Output-port FIFO of the NoC router: 4-phase req/ack in, DEPTH-entry
// circular buffer, registered 4-phase req/ack out, live occupancy count.
//
// Ports:
//   clk, reset                   rising-edge clock, sync active-high reset
//   in_req / in_ack / in_data    upstream 4-phase channel (from the arbiter)
//   out_req / out_ack / out_data downstream 4-phase link (registered data)
//   count                        occupancy, 0..DEPTH
//   pkt_total, overflow_stall    present only with NOC_OUT_BUF_STATS_EN
//
// Optional feature macro: NOC_OUT_BUF_STATS_EN (pop counter + stall flag).
module noc_out_port_buffer #(
  parameter int WIDTH_packet = 57,
  parameter int DEPTH        = 4,
  localparam int CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_req,
  output logic                    in_ack,
  input  logic [WIDTH_packet-1:0] in_data,
  output logic                    out_req,
  input  logic                    out_ack,
  output logic [WIDTH_packet-1:0] out_data,
`ifdef NOC_OUT_BUF_STATS_EN
  output logic [15:0]             pkt_total,
  output logic [0:0]              overflow_stall,
`endif
  output logic [CNT_W-1:0]        count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {
    IN_IDLE,
    IN_ACK
  } in_st_e;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_REQ,
    OUT_RTZ
  } out_st_e;

  in_st_e  in_st_q, in_st_d;
  out_st_e out_st_q, out_st_d;

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic                    in_ack_q, in_ack_d;
  logic                    out_req_q, out_req_d;
  logic [WIDTH_packet-1:0] out_data_q, out_data_d;
  logic [WIDTH_packet-1:0] mem_q [DEPTH];

  logic full, empty;
  logic wr_en, pop, load;

  // Extra pointer bit separates full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1])
              && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      in_st_q    <= IN_IDLE;
      out_st_q   <= OUT_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      in_ack_q   <= 1'b0;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      in_st_q    <= in_st_d;
      out_st_q   <= out_st_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      in_ack_q   <= in_ack_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage needs no reset: the cleared pointers mark every slot empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  // Next-state logic
  always_comb begin
    in_st_d = in_st_q;
    unique case (in_st_q)
      IN_IDLE: if (in_req && !full) in_st_d = IN_ACK;
      IN_ACK:  if (!in_req)         in_st_d = IN_IDLE;
      default: in_st_d = IN_IDLE;
    endcase
  end

  always_comb begin
    out_st_d = out_st_q;
    unique case (out_st_q)
      OUT_IDLE: if (!empty)  out_st_d = OUT_REQ;
      OUT_REQ:  if (out_ack) out_st_d = OUT_RTZ;
      OUT_RTZ:  if (!out_ack) out_st_d = OUT_IDLE;
      default:  out_st_d = OUT_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    wr_en = (in_st_q == IN_IDLE) && in_req && !full;
    pop   = (out_st_q == OUT_REQ) && out_ack;
    load  = (out_st_q == OUT_IDLE) && !empty;

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    in_ack_d = in_ack_q;
    if (wr_en) begin
      in_ack_d = 1'b1;
    end else if ((in_st_q == IN_ACK) && !in_req) begin
      in_ack_d = 1'b0;
    end

    out_req_d = out_req_q;
    if (load) begin
      out_req_d = 1'b1;
    end else if (pop) begin
      out_req_d = 1'b0;
    end

    // A load never reads the slot being written: that slot is free.
    out_data_d = load ? mem_q[rd_ptr_q[AW-1:0]] : out_data_q;
  end

  assign in_ack   = in_ack_q;
  assign out_req  = out_req_q;
  assign out_data = out_data_q;
  assign count    = wr_ptr_q - rd_ptr_q;

`ifdef NOC_OUT_BUF_STATS_EN
  logic [15:0] pkt_total_q, pkt_total_d;

  always_comb begin
    pkt_total_d = pkt_total_q + {15'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_total_q <= '0;
    end else begin
      pkt_total_q <= pkt_total_d;
    end
  end

  assign pkt_total      = pkt_total_q;
  assign overflow_stall = in_req && full && (in_st_q == IN_IDLE);
`endif

endmodule

// File: tb/tb_noc_out_port_buffer.sv
// Scoreboard bench for noc_out_port_buffer: producer pushes accepted
// packets into a queue, an independent consumer pops and compares.
module tb_noc_out_port_buffer;

  localparam int W  = 57;
  localparam int D  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_req;
  logic          in_ack;
  logic [W-1:0]  in_data;
  logic          out_req;
  logic          out_ack;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;
`ifdef NOC_OUT_BUF_STATS_EN
  logic [15:0]   pkt_total;
  logic [0:0]    overflow_stall;
`endif

  noc_out_port_buffer #(
    .WIDTH_packet(W),
    .DEPTH(D)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_req(in_req),
    .in_ack(in_ack),
    .in_data(in_data),
    .out_req(out_req),
    .out_ack(out_ack),
    .out_data(out_data),
`ifdef NOC_OUT_BUF_STATS_EN
    .pkt_total(pkt_total),
    .overflow_stall(overflow_stall),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_popped = 0;
  logic [W-1:0] exp_q[$];
  bit cons_hold = 1'b1;
  bit cons_busy = 1'b0;
  int cons_dly  = 0;
  bit cnt_chk   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic check_pop();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_output: got %0h expected none", out_data);
    end else begin
      e = exp_q.pop_front();
      chk("order", 64'(out_data), 64'(e));
      n_popped++;
    end
  endtask

  // Consumer / monitor
  initial begin
    int t;
    out_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!cons_hold && out_req && !out_ack) begin
        cons_busy = 1'b1;
        repeat ($urandom_range(0, cons_dly)) @(negedge clk);
        check_pop();
        out_ack = 1'b1;
        t = 0;
        while (out_req && t < 50) begin
          @(negedge clk);
          t++;
        end
        if (out_req) chk("out_req_drop_timeout", 64'(out_req), 64'(0));
        repeat ($urandom_range(0, cons_dly)) @(negedge clk);
        out_ack = 1'b0;
        cons_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cnt_chk) chk("count_le_depth", 64'(count <= CW'(D)), 64'(1));
  end

  task automatic send(input logic [W-1:0] d, input int maxdly);
    int t;
    repeat ($urandom_range(0, maxdly)) @(negedge clk);
    in_data = d;
    in_req  = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ack && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ack) begin
      chk("in_ack_timeout", 64'(in_ack), 64'(1));
      in_req = 1'b0;
    end else begin
      exp_q.push_back(d);
      in_req = 1'b0;
      @(negedge clk);
      chk("in_ack_fall", 64'(in_ack), 64'(0));
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || cons_busy || out_req || count != 0)
           && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue", 64'(exp_q.size()), 64'(0));
    chk("drain_count", 64'(count), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int seen;
    in_req  = 1'b0;
    in_data = '0;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ack", 64'(in_ack), 64'(0));
    chk("rst_out_req", 64'(out_req), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    reset = 1'b0;

    // Single packet, latency check
    cons_hold = 1'b0;
    cons_dly  = 0;
    @(negedge clk);
    in_data = 57'h0_0000_00AB;
    in_req  = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ack && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("single_ack", 64'(in_ack), 64'(1));
    exp_q.push_back(57'h0_0000_00AB);
    chk("single_count1", 64'(count), 64'(1));
    in_req = 1'b0;
    @(negedge clk);
    chk("single_latency", 64'(out_req), 64'(1));
    wait_drain();
    chk("single_hold_data", 64'(out_data), 64'h0AB);

    // Reset in the middle of a transfer
    cons_hold = 1'b1;
    send(57'd1, 0);
    send(57'd2, 0);
    chk("pre_rst_count", 64'(count), 64'(2));
    in_data = 57'd3;
    in_req  = 1'b1;
    reset   = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_in_ack", 64'(in_ack), 64'(0));
    chk("midrst_out_req", 64'(out_req), 64'(0));
    chk("midrst_count", 64'(count), 64'(0));
    in_req = 1'b0;
    reset  = 1'b0;
    exp_q.delete();
    n_popped = 0;
    cons_hold = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_req) seen++;
    end
    chk("midrst_no_drain", 64'(seen), 64'(0));
    chk("midrst_count_after", 64'(count), 64'(0));

    // Fill with the consumer stalled
    cons_hold = 1'b1;
    for (int i = 0; i < 4; i++) send(W'(i), 0);
    chk("fill_count", 64'(count), 64'(4));
    fork
      send(57'd4, 0);
      begin
        repeat (5) @(negedge clk);
        chk("fill_5th_noack", 64'(in_ack), 64'(0));
        chk("fill_count_hold", 64'(count), 64'(4));
`ifdef NOC_OUT_BUF_STATS_EN
        chk("overflow_stall", 64'(overflow_stall), 64'(1));
`endif
        cons_hold = 1'b0;
      end
    join
    wait_drain();

    // Simultaneous write and pop at count 2
    cons_hold = 1'b1;
    send(57'd10, 0);
    send(57'd11, 0);
    @(negedge clk);
    chk("simul_pre_count", 64'(count), 64'(2));
    chk("simul_pre_req", 64'(out_req), 64'(1));
    check_pop();
    out_ack = 1'b1;
    in_data = 57'd12;
    in_req  = 1'b1;
    @(negedge clk);
    chk("simul_count", 64'(count), 64'(2));
    chk("simul_in_ack", 64'(in_ack), 64'(1));
    chk("simul_out_req", 64'(out_req), 64'(0));
    exp_q.push_back(57'd12);
    in_req  = 1'b0;
    out_ack = 1'b0;
    @(negedge clk);
    cons_hold = 1'b0;
    wait_drain();

    // Wrap: 20 packets with random partner delays, from a fresh reset
    cons_hold = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    n_popped = 0;
    cons_hold = 1'b0;
    cons_dly  = 3;
    cnt_chk   = 1'b1;
    for (int i = 0; i < 20; i++) send(W'(i), 3);
    wait_drain();
    chk("wrap_popped", 64'(n_popped), 64'(20));
`ifdef NOC_OUT_BUF_STATS_EN
    chk("pkt_total", 64'(pkt_total), 64'(20));
`endif

    // Random payloads
    for (int i = 0; i < 30; i++) send(W'({$urandom(), $urandom()}), 3);
    wait_drain();
    chk("rand_popped", 64'(n_popped), 64'(50));
    cnt_chk = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
